alu_mul_sequencer: RTL and testbench
====================================

Name: alu_mul_sequencer

Overview:
- Sequences the multi-cycle multiply path of the EX stage. When the ALU control code selects MUL, it latches the operands and runs an iterative shift-add multiplier.
- Holds the pipeline with a stall until the product is ready, then presents the low WIDTH bits of the product for one cycle.
- Non-MUL ALU codes pass through with no stall. Those results come from the single-cycle ALU, not from this block.

Parameters:
- WIDTH, 32, operand and result width in bits.
- BITS_PER_CYCLE, 1, multiplier bits retired per iteration. Legal values are 1, 2 and 4, and the value must divide WIDTH.
- EARLY_EXIT, 1, when 1, finish as soon as the remaining multiplier bits are all zero.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  EX stage holds a valid instruction.
- flush_i  in  1  EX instruction is squashed (branch/exception); aborts any multiply.
- ALUCtrl_i  in  3  ALU control code from ALU control: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 MUL.
- data1_i  in  WIDTH  multiplicand (rs1).
- data2_i  in  WIDTH  multiplier (rs2).
- stall_o  out  1  hold PC, IF/ID and ID/EX this cycle.
- result_o  out  WIDTH  low WIDTH bits of data1_i*data2_i.
- result_valid_o  out  1  result_o is valid this cycle.

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Reset values: state IDLE, stall_o 0, result_valid_o 0, result_o 0, and all internal registers 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - stall_o = valid_i & (ALUCtrl_i==MUL) & ~flush_i. This is combinational, so the stall covers the accept cycle.
  - On that condition: mcand_q<=data1_i, mplier_q<=data2_i, acc_q<=0, cnt_q<=0, and go to BUSY.
  - Otherwise stay in IDLE with stall_o 0.
- BUSY:
  - stall_o = 1.
  - If EARLY_EXIT and mplier_q==0: no iteration this cycle; go to DONE.
  - Otherwise perform one iteration:
    - acc_q <= acc_q + mplier_q[K-1:0]*mcand_q, where K = BITS_PER_CYCLE.
    - mcand_q <= mcand_q<<K.
    - mplier_q <= mplier_q>>K.
    - cnt_q++.
  - All arithmetic is truncated to WIDTH bits; overflow is discarded silently.
  - When the iteration just performed is number WIDTH/K, go to DONE.
- DONE:
  - stall_o = 0, result_valid_o = 1, result_o = acc_q. The pipeline advances the MUL out of EX this cycle.
  - Next state is always IDLE. A MUL in the following cycle is a new instruction and is accepted normally.
- result_o holds acc_q in every state. Consumers qualify it with result_valid_o only.
- Latency:
  - Without early exit: 1 accept cycle + WIDTH/K BUSY cycles stalled, then DONE. For WIDTH=32, K=1 that is 33 stall cycles with the result on cycle 33.
  - With early exit: 1 + (index of the highest set bit of data2_i)/K + 2 cycles, capped at the value without early exit.
- flush_i:
  - In BUSY: next state IDLE, stall_o 0 that cycle, and no result_valid_o.
  - In DONE: result_valid_o is still driven, since the consumer gates on its own flush.
- rst_i mid-operation takes priority over everything: return to IDLE next edge with all outputs at reset values.
- Signed or unsigned operands give identical low WIDTH bits; no sign handling is needed.
- valid_i or ALUCtrl_i changing during BUSY is ignored, because the operands are already latched.

Decomposition:
- Shared package alu_pkg holds:
  - ALU control code constants: ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_MUL=3'b111.
  - The state enum: IDLE/BUSY/DONE.
  - These codes are reused by ALU control and the ALU.
- One sub-module, mul_step: combinational acc + mplier[K-1:0]*mcand. It is instantiated once, and the FSM and registers stay in the parent.

Test Plan:
- Non-MUL pass-through: valid_i=1, ALUCtrl_i=010, data 7/9 -> stall_o 0 and result_valid_o 0 in every cycle; state stays IDLE.
- Full-length MUL with EARLY_EXIT=0, K=1: 0xFFFFFFFF*0xFFFFFFFF -> stall_o high for exactly 33 cycles starting at the accept cycle; on cycle 33 result_valid_o=1 and result_o=0x00000001.
- Early exit with K=1: 3*5 -> stall_o high for 5 cycles (accept + 3 iterations + 1 zero-check), then DONE with result_o=15; 7*0 -> 2 stall cycles, then result_o=0.
- Back-to-back MULs: 6*7, then 2*0x80000000 issued the cycle after DONE -> first result_o=42; second accepted without a gap, result_o=0 (truncation).
- Flush mid-BUSY: start 0x1234*0x5678, assert flush_i on BUSY cycle 4 -> next cycle IDLE, stall_o 0, and no result_valid_o pulse follows.
- Reset mid-BUSY: rst_i on BUSY cycle 10 -> next edge stall_o=0, result_valid_o=0, result_o=0; a subsequent 4*4 gives 16 with normal latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions.
// Holds the ALU control codes that the ALU control unit, the single-cycle
// ALU and the multiply sequencer all decode, plus the state encoding of the
// multiply sequencer.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_step.sv
// One shift-add multiply step (purely combinational).
//   acc   in  WIDTH  running partial product
//   mcand in  WIDTH  multiplicand, already shifted for this step
//   digit in  K      low K bits of the remaining multiplier
//   sum   out WIDTH  acc + digit*mcand, truncated to WIDTH bits
module mul_step #(
    parameter int WIDTH = 32,
    parameter int K     = 1
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mcand,
    input  logic [K-1:0]     digit,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] digit_ext;

    assign digit_ext = WIDTH'(digit);
    // Only the low WIDTH bits of the product are ever consumed.
    assign sum = acc + digit_ext * mcand;

endmodule

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle multiply sequencer for the EX stage.
// Latches the operands when a valid MUL arrives, runs an iterative shift-add
// multiplier (BITS_PER_CYCLE multiplier bits per step, legal values 1, 2 and 4,
// which must divide WIDTH) and stalls the pipeline until the low WIDTH bits of
// the product are ready.
//   clk_i          in   clock
//   rst_i          in   synchronous active-high reset
//   valid_i        in   EX holds a valid instruction
//   flush_i        in   EX instruction squashed; aborts a running multiply
//   ALUCtrl_i      in   ALU control code (only ALU_MUL is acted on)
//   data1_i        in   multiplicand
//   data2_i        in   multiplier
//   stall_o        out  hold PC, IF/ID and ID/EX this cycle
//   result_o       out  accumulator; meaningful only with result_valid_o
//   result_valid_o out  product is presented this cycle
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a MUL; stall raised combinationally on accept
// BUSY  | iterating; stall held until done, flushed, or early exit
// DONE  | product on result_o for one cycle, pipeline released
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int EARLY_EXIT     = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             stall_o,
    output logic [WIDTH-1:0] result_o,
    output logic             result_valid_o
);

    localparam int ITERS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(ITERS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ITERS - 1);

    mul_state_e       state_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             exit_now;
    logic [WIDTH-1:0] step_sum;

    assign accept   = valid_i && (ALUCtrl_i == ALU_MUL) && !flush_i;
    // Nothing left to add once the remaining multiplier bits are all zero.
    assign exit_now = (EARLY_EXIT != 0) && (mplier_q == '0);

    mul_step #(
        .WIDTH (WIDTH),
        .K     (BITS_PER_CYCLE)
    ) u_mul_step (
        .acc   (acc_q),
        .mcand (mcand_q),
        .digit (mplier_q[BITS_PER_CYCLE-1:0]),
        .sum   (step_sum)
    );

    // Stall must be combinational so it already covers the accept cycle.
    always_comb begin
        stall_o = 1'b0;
        case (state_q)
            IDLE:    stall_o = accept;
            BUSY:    stall_o = !flush_i;
            default: stall_o = 1'b0;
        endcase
    end

    assign result_valid_o = (state_q == DONE);
    assign result_o       = acc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        mcand_q  <= data1_i;
                        mplier_q <= data2_i;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else if (exit_now) begin
                        state_q <= DONE;
                    end else begin
                        acc_q    <= step_sum;
                        mcand_q  <= mcand_q << BITS_PER_CYCLE;
                        mplier_q <= mplier_q >> BITS_PER_CYCLE;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_IDX) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Flush is ignored here; the consumer gates on its own flush.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;
    import alu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        flush_i;
    logic [2:0]  ALUCtrl_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic        stall_o;
    logic [31:0] result_o;
    logic        result_valid_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    alu_mul_sequencer #(
        .WIDTH          (32),
        .BITS_PER_CYCLE (1),
        .EARLY_EXIT     (1)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .flush_i        (flush_i),
        .ALUCtrl_i      (ALUCtrl_i),
        .data1_i        (data1_i),
        .data2_i        (data2_i),
        .stall_o        (stall_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every result pulse must match the oldest outstanding product.
    always @(negedge clk_i) begin
        if (!rst_i && result_valid_o) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got 0x%08h with nothing expected", result_o);
            end else begin
                check("mul_result", result_o, exp_q.pop_front());
            end
        end
    end

    // Issue a MUL in the next cycle and measure the stall run length.
    // Inputs stay asserted while stalled, as a held ID/EX register would.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input int exp_stalls);
        int stalls;
        bit done;
        @(posedge clk_i); #1;
        valid_i = 1'b1; ALUCtrl_i = ALU_MUL; data1_i = a; data2_i = b;
        exp_q.push_back(exp_res);
        stalls = 0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk_i);
            if (stall_o) stalls++;
            else done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL stall_timeout: stall still high after 100 cycles");
        end
        check("stall_cycles", 32'(stalls), 32'(exp_stalls));
        check("done_valid", {31'd0, result_valid_o}, 32'd1);
    endtask

    task automatic go_idle();
        @(posedge clk_i); #1;
        valid_i = 1'b0; ALUCtrl_i = ALU_AND; flush_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
        ALUCtrl_i = ALU_AND; data1_i = '0; data2_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_stall", {31'd0, stall_o}, 32'd0);
        check("reset_valid", {31'd0, result_valid_o}, 32'd0);
        check("reset_result", result_o, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Non-MUL codes never stall and never produce a result here.
        valid_i = 1'b1; data1_i = 32'd7; data2_i = 32'd9;
        foreach (ALUCtrl_i[i]) ; // keep ALUCtrl_i width visible to readers
        for (int i = 0; i < 4; i++) begin
            logic [2:0] codes [4];
            codes = '{ALU_ADD, ALU_AND, ALU_OR, ALU_SUB};
            ALUCtrl_i = codes[i];
            @(negedge clk_i);
            check("nonmul_stall", {31'd0, stall_o}, 32'd0);
            check("nonmul_valid", {31'd0, result_valid_o}, 32'd0);
            @(posedge clk_i); #1;
        end

        // A MUL flushed in the same cycle is not accepted.
        ALUCtrl_i = ALU_MUL; flush_i = 1'b1;
        @(negedge clk_i);
        check("flushed_accept_stall", {31'd0, stall_o}, 32'd0);
        go_idle();
        @(negedge clk_i);
        check("flushed_accept_idle", {31'd0, stall_o}, 32'd0);

        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
        go_idle();
        run_mul(32'd3, 32'd5, 32'd15, 5);
        go_idle();
        run_mul(32'd7, 32'd0, 32'd0, 2);
        go_idle();
        // Back-to-back: second MUL lands in the cycle right after DONE.
        run_mul(32'd6, 32'd7, 32'd42, 5);
        run_mul(32'd2, 32'h8000_0000, 32'd0, 33);
        run_mul(32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 7);
        run_mul(32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 5);
        go_idle();

        // Flush on BUSY cycle 4: no result may follow.
        @(posedge clk_i); #1;
        valid_i = 1'b1; ALUCtrl_i = ALU_MUL; data1_i = 32'h1234; data2_i = 32'h5678;
        repeat (4) begin
            @(posedge clk_i); #1;
        end
        flush_i = 1'b1;
        @(negedge clk_i);
        check("flush_stall_same_cycle", {31'd0, stall_o}, 32'd0);
        go_idle();
        @(negedge clk_i);
        check("flush_next_stall", {31'd0, stall_o}, 32'd0);
        begin
            int pulses = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk_i);
                if (result_valid_o) pulses++;
            end
            check("flush_no_result", 32'(pulses), 32'd0);
        end

        // Reset on BUSY cycle 10, then a normal 4*4.
        @(posedge clk_i); #1;
        valid_i = 1'b1; ALUCtrl_i = ALU_MUL; data1_i = 32'hFFFF; data2_i = 32'hFFFF_FFFF;
        repeat (10) begin
            @(posedge clk_i); #1;
        end
        rst_i = 1'b1; valid_i = 1'b0;
        @(negedge clk_i);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        ALUCtrl_i = ALU_AND;
        @(negedge clk_i);
        check("rst_mid_stall", {31'd0, stall_o}, 32'd0);
        check("rst_mid_valid", {31'd0, result_valid_o}, 32'd0);
        check("rst_mid_result", result_o, 32'd0);
        run_mul(32'd4, 32'd4, 32'd16, 5);
        go_idle();

        repeat (5) @(posedge clk_i);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
